// File: rtl/nrf_spi_responder.sv
// SPI mode-0 target emulating a subset of the nRF24L01 command set (register file + payload FIFO).
// Optional irq_n output is enabled by defining NRF_RESP_IRQ_EN.
module nrf_spi_responder #(
    parameter int unsigned REG_COUNT   = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk_10,
    input  logic                        rst,
    input  logic                        sck,
    input  logic                        csn,
    input  logic                        mosi,
    output logic                        miso,
    output logic                        miso_oe,
    output logic                        cmd_strobe,
    output logic [7:0]                  cmd_byte,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_ovf
`ifdef NRF_RESP_IRQ_EN
    ,
    output logic                        irq_n
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FifoFull = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StCmd, StDataR, StDataW, StPayR, StPayW, StIgnore
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic                   cmd_strobe_q, cmd_strobe_d;
    logic [7:0]             cmd_byte_q, cmd_byte_d;
    logic [4:0]             addr_q, addr_d;
    logic                   wr_done_q, wr_done_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             fifo_mem_q [FIFO_DEPTH];
    logic [7:0]             reg_q [REG_COUNT];

    logic       sck_s, csn_s, mosi_s, sck_rise, sck_fall, csn_fall, csn_rise;
    logic       not_empty, want_pop, want_push, push, reg_we;
    logic [7:0] rx_byte, tx_load, rd_data, status;
    logic [4:0] rd_addr;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;
    assign csn_rise = csn_s & ~csn_prev_q;

    // csn chain resets low so a csn already low at reset release never looks like a fall.
    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign not_empty = (count_q != '0);
    assign status    = {1'b0, not_empty, 2'b00, not_empty ? 3'b000 : 3'b111, count_q == FifoFull};
    assign rx_byte   = {rx_shift_q, mosi_s};
    assign rd_addr   = (state_q == StCmd) ? rx_byte[4:0] : addr_q;

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rd_addr == 5'(i)) rd_data = reg_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        cmd_strobe_d = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        addr_d       = addr_q;
        wr_done_d    = wr_done_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        tx_load      = 8'h00;
        want_pop     = 1'b0;
        want_push    = 1'b0;
        push         = 1'b0;
        reg_we       = 1'b0;

        if (csn_fall) begin
            state_d    = StCmd;
            bit_cnt_d  = 3'd0;
            miso_d     = status[7];
            tx_shift_d = {status[6:0], 1'b0};
            miso_oe_d  = 1'b1;
        end else if (state_q != StIdle) begin
            if (sck_rise) begin
                rx_shift_d = rx_byte[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        StCmd: begin
                            cmd_strobe_d = 1'b1;
                            cmd_byte_d   = rx_byte;
                            addr_d       = rx_byte[4:0];
                            state_d      = StIgnore;
                            if (rx_byte[7:5] == 3'b000) begin
                                state_d = StDataR;
                                tx_load = rd_data;
                            end else if (rx_byte[7:5] == 3'b001) begin
                                state_d   = StDataW;
                                wr_done_d = 1'b0;
                            end else if (rx_byte == 8'h61) begin
                                state_d  = StPayR;
                                want_pop = 1'b1;
                            end else if (rx_byte == 8'hA0) begin
                                state_d = StPayW;
                            end else if (rx_byte == 8'hE1 || rx_byte == 8'hE2) begin
                                count_d  = '0;
                                rd_ptr_d = wr_ptr_q;
                                ovf_d    = 1'b0;
                            end
                        end
                        StDataR: tx_load = rd_data;
                        StDataW: begin
                            reg_we    = ~wr_done_q;
                            wr_done_d = 1'b1;
                        end
                        StPayR:  want_pop = 1'b1;
                        StPayW:  want_push = 1'b1;
                        default: ;
                    endcase
                    tx_shift_d = tx_load;
                end
            end else if (sck_fall) begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
            // A boundary coinciding with csn rise has already been committed above.
            if (csn_rise) begin
                state_d   = StIdle;
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
            end
        end

        if (want_pop && not_empty) begin
            tx_load    = fifo_mem_q[rd_ptr_q];
            tx_shift_d = tx_load;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
        end
        if (want_push) begin
            if (count_q == FifoFull) begin
                ovf_d = 1'b1;
            end else begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'h00;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cmd_strobe_q <= 1'b0;
            cmd_byte_q   <= 8'h00;
            addr_q       <= 5'd0;
            wr_done_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_byte_q   <= cmd_byte_d;
            addr_q       <= addr_d;
            wr_done_q    <= wr_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_q[i] <= (i == 0) ? 8'h08 : (i == 5) ? 8'h02 : 8'h00;
            end
        end else if (reg_we) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (addr_q == 5'(i)) reg_q[i] <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk_10) begin
        if (push) fifo_mem_q[wr_ptr_q] <= rx_byte;
    end

`ifdef NRF_RESP_IRQ_EN
    logic irq_clr_q, irq_clr_d, irq_n_q, irq_n_d;

    always_comb begin
        irq_clr_d = irq_clr_q;
        if (push) begin
            irq_clr_d = 1'b0;
        end else if (reg_we && addr_q == 5'd7 && rx_byte[6]) begin
            irq_clr_d = 1'b1;
        end
        irq_n_d = (count_d == '0) || irq_clr_d;
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            irq_clr_q <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            irq_clr_q <= irq_clr_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`endif

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_byte   = cmd_byte_q;
    assign fifo_count = count_q;
    assign fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder against a transaction-level model of the command set.
// Define NRF_RESP_IRQ_EN to also exercise the irq_n output.
module tb_nrf_spi_responder;

    localparam int HALF      = 6;
    localparam int REG_COUNT = 8;
    localparam int DEPTH     = 32;

    logic       clk_10 = 1'b0;
    logic       rst    = 1'b1;
    logic       sck    = 1'b0;
    logic       csn    = 1'b1;
    logic       mosi   = 1'b0;
    logic       miso, miso_oe, cmd_strobe, fifo_ovf;
    logic [7:0] cmd_byte;
    logic [5:0] fifo_count;
`ifdef NRF_RESP_IRQ_EN
    logic       irq_n;
`endif

    nrf_spi_responder #(
        .REG_COUNT  (REG_COUNT),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk_10    (clk_10),
        .rst       (rst),
        .sck       (sck),
        .csn       (csn),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .cmd_strobe(cmd_strobe),
        .cmd_byte  (cmd_byte),
        .fifo_count(fifo_count),
        .fifo_ovf  (fifo_ovf)
`ifdef NRF_RESP_IRQ_EN
        ,
        .irq_n     (irq_n)
`endif
    );

    always #50 clk_10 = ~clk_10;

    int         n_checks = 0;
    int         n_errors = 0;
    int         strobes  = 0;
    logic       model_idle = 1'b0;
    logic [7:0] tx_buf [40];
    logic [7:0] rx_buf [40];
    logic [7:0] exp_buf [40];
    logic [7:0] m_reg [32];
    logic [7:0] m_q [$];
    logic       m_ovf;
    logic [7:0] junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_10);
    endtask

    function automatic logic [7:0] m_status();
        logic ne;
        ne = (m_q.size() != 0);
        return {1'b0, ne, 2'b00, ne ? 3'b000 : 3'b111, m_q.size() == DEPTH};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
        m_reg[0] = 8'h08;
        m_reg[5] = 8'h02;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // Expected miso bytes for n full bytes; every byte boundary loads (and may pop) the next byte.
    task automatic model_txn(input int n);
        logic [7:0] c, e;
        if (n == 0) return;
        exp_buf[0] = m_status();
        c = tx_buf[0];
        if (c == 8'hE1 || c == 8'hE2) begin
            m_q.delete();
            m_ovf = 1'b0;
        end
        if (c[7:5] == 3'b001 && n > 1 && int'(c[4:0]) < REG_COUNT) m_reg[c[4:0]] = tx_buf[1];
        for (int k = 1; k <= n; k++) begin
            e = 8'h00;
            if (c[7:5] == 3'b000 && int'(c[4:0]) < REG_COUNT) e = m_reg[c[4:0]];
            if (c == 8'h61 && m_q.size() > 0) e = m_q.pop_front();
            if (c == 8'hA0 && k < n) begin
                if (m_q.size() < DEPTH) m_q.push_back(tx_buf[k]);
                else m_ovf = 1'b1;
            end
            if (k < n) exp_buf[k] = e;
        end
    endtask

    task automatic shift_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            mosi = tx[b];
            wait_clks(HALF);
            rx[b] = miso;
            sck = 1'b1;
            wait_clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic txn(input int n, input int part);
        model_txn(n);
        model_idle = 1'b0;
        strobes = 0;
        csn = 1'b0;
        wait_clks(HALF);
        check("oe_during_txn", 32'(miso_oe), 32'd1);
        for (int k = 0; k < n; k++) shift_bits(tx_buf[k], 8, rx_buf[k]);
        if (part > 0) shift_bits(tx_buf[n], part, junk);
        wait_clks(HALF);
        csn = 1'b1;
        wait_clks(8);
        for (int k = 0; k < n; k++) check($sformatf("miso_byte%0d", k), 32'(rx_buf[k]), 32'(exp_buf[k]));
        check("strobe_count", 32'(strobes), 32'(n > 0 ? 1 : 0));
        check("cmd_byte", 32'(cmd_byte), 32'(tx_buf[0]));
        model_idle = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_10);
                if (cmd_strobe) strobes++;
                if (model_idle) begin
                    check("idle_fifo_count", 32'(fifo_count), 32'(m_q.size()));
                    check("idle_fifo_ovf", 32'(fifo_ovf), 32'(m_ovf));
                    check("idle_miso_oe", 32'(miso_oe), 32'd0);
                    check("idle_miso", 32'(miso), 32'd0);
                end
            end
        join_none

        m_reset();
        wait_clks(5);
        rst = 1'b0;
        wait_clks(6);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'h00);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_fifo_ovf", 32'(fifo_ovf), 32'd0);
        model_idle = 1'b1;

        tx_buf[0] = 8'hFF; txn(1, 0);
        check("nop_status", 32'(rx_buf[0]), 32'h0E);
        check("nop_cmd_byte", 32'(cmd_byte), 32'hFF);

        tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; txn(2, 0);
        check("reg0_reset", 32'(rx_buf[1]), 32'h08);
        tx_buf[0] = 8'h25; tx_buf[1] = 8'h4C; txn(2, 0);
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; txn(3, 0);
        check("reg5_read", 32'(rx_buf[1]), 32'h4C);
        check("reg5_reread", 32'(rx_buf[2]), 32'h4C);
        tx_buf[0] = 8'h1F; tx_buf[1] = 8'hFF; txn(2, 0);
        check("reg1f_read", 32'(rx_buf[1]), 32'h00);
        tx_buf[0] = 8'h21; tx_buf[1] = 8'h5A; tx_buf[2] = 8'h77; txn(3, 0);
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h00; txn(2, 0);
        check("reg1_first_only", 32'(rx_buf[1]), 32'h5A);

        tx_buf[0] = 8'hA0; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33; txn(4, 0);
        check("fifo_count_3", 32'(fifo_count), 32'd3);
        tx_buf[0] = 8'hFF; txn(1, 0);
        check("status_3", 32'(rx_buf[0]), 32'h40);
        tx_buf[0] = 8'h61;
        for (int i = 1; i <= 4; i++) tx_buf[i] = 8'hFF;
        txn(5, 0);
        check("pop_0", 32'(rx_buf[1]), 32'h11);
        check("pop_1", 32'(rx_buf[2]), 32'h22);
        check("pop_2", 32'(rx_buf[3]), 32'h33);
        check("pop_empty", 32'(rx_buf[4]), 32'h00);
        check("fifo_count_0", 32'(fifo_count), 32'd0);

        tx_buf[0] = 8'hA0;
        for (int i = 1; i <= 33; i++) tx_buf[i] = 8'(i * 7);
        txn(34, 0);
        check("fifo_count_full", 32'(fifo_count), 32'd32);
        check("fifo_ovf_set", 32'(fifo_ovf), 32'd1);
        tx_buf[0] = 8'hFF; txn(1, 0);
        check("status_full", 32'(rx_buf[0]), 32'h41);
        tx_buf[0] = 8'hE1; txn(1, 0);
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_ovf", 32'(fifo_ovf), 32'd0);

        tx_buf[0] = 8'h23; tx_buf[1] = 8'hAA; txn(1, 5);
        check("partial_oe", 32'(miso_oe), 32'd0);
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; txn(2, 0);
        check("partial_reg3", 32'(rx_buf[1]), 32'h00);

        model_idle = 1'b0;
        csn = 1'b0;
        wait_clks(HALF);
        shift_bits(8'hA0, 8, junk);
        shift_bits(8'h01, 8, junk);
        shift_bits(8'h02, 8, junk);
        shift_bits(8'h03, 4, junk);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        m_reset();
        strobes = 0;
        wait_clks(HALF);
        shift_bits(8'hFF, 8, junk);
        wait_clks(HALF);
        check("post_rst_strobe", 32'(strobes), 32'd0);
        check("post_rst_oe", 32'(miso_oe), 32'd0);
        check("post_rst_count", 32'(fifo_count), 32'd0);
        csn = 1'b1;
        wait_clks(8);
        model_idle = 1'b1;
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; txn(2, 0);
        check("post_rst_reg0", 32'(rx_buf[1]), 32'h08);

`ifdef NRF_RESP_IRQ_EN
        tx_buf[0] = 8'hA0; tx_buf[1] = 8'h5A; txn(2, 0);
        check("irq_asserted", 32'(irq_n), 32'd0);
        tx_buf[0] = 8'h61; tx_buf[1] = 8'h00; txn(2, 0);
        check("irq_pop_data", 32'(rx_buf[1]), 32'h5A);
        check("irq_released", 32'(irq_n), 32'd1);
`endif

        model_idle = 1'b0;
        wait_clks(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
